// File: rtl/hub75_pkg.sv
// Shared HUB75 definitions: panel geometry defaults, the upper/lower
// pixel pair and the frame reader FSM states. The shifter imports the
// same package so both sides agree on the pair layout.
package hub75_pkg;

  localparam int DEF_WIDTH = 64;
  localparam int DEF_ROWS  = 32;

  // One column of the two half-panels, each {B,G,R}
  typedef struct packed {
    logic [2:0] rgb1;
    logic [2:0] rgb2;
  } hub75_pair_t;

  typedef enum logic [1:0] {
    ST_TOP  = 2'd0,
    ST_BOT  = 2'd1,
    ST_CAP  = 2'd2,
    ST_HOLD = 2'd3
  } hub75_state_e;

endpackage

// File: rtl/hub75_frame_reader.sv
// HUB75 frame reader: walks a 1-bit-per-channel framebuffer in a
// synchronous RAM (1-cycle read latency) and hands out one upper/lower
// pixel pair per column over valid/ready.
// Optional feature: define HUB75_FB_SWAP_EN for double-buffered frames
// (bank bit as address MSB, swap applied at the frame boundary).
module hub75_frame_reader
  import hub75_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int ROWS  = DEF_ROWS,
`ifdef HUB75_FB_SWAP_EN
  parameter int AW    = $clog2(2*ROWS*WIDTH) + 1
`else
  parameter int AW    = $clog2(2*ROWS*WIDTH)
`endif
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  output logic                    fb_rd,
  output logic [AW-1:0]           fb_addr,
  input  logic [2:0]              fb_rdata,
  output logic                    pix_valid,
  input  logic                    pix_ready,
  output logic [2:0]              pix_rgb1,
  output logic [2:0]              pix_rgb2,
  output logic [$clog2(ROWS)-1:0] pix_line,
  output logic                    pix_last,
  input  logic                    swap_req,
  output logic                    swap_ack
);

  localparam int CW = $clog2(WIDTH);
  localparam int LW = $clog2(ROWS);
  localparam logic [CW-1:0] COL_LAST  = CW'(WIDTH - 1);
  localparam logic [LW-1:0] LINE_LAST = LW'(ROWS - 1);

  hub75_state_e  state_r;
  logic [CW-1:0] col_r;
  logic [LW-1:0] line_r;
  logic [2:0]    top_hold_r;
  hub75_pair_t   pair_r;
  logic          pix_valid_r;
  logic [LW-1:0] pix_line_r;
  logic          pix_last_r;
  logic [AW-1:0] addr_hold_r;
  logic [AW-1:0] top_addr_s;
  logic [AW-1:0] bot_addr_s;
  logic [AW-1:0] addr_s;
  logic          rd_s;
  logic          xfer_s;

  assign xfer_s = (state_r == ST_HOLD) && pix_valid_r && pix_ready;

`ifdef HUB75_FB_SWAP_EN
  logic bank_r;
  logic pend_r;
  logic swap_ack_r;
  logic pend_s;
  logic wrap_s;

  // A request in the same cycle as the boundary transfer counts immediately
  assign pend_s = pend_r | swap_req;
  assign wrap_s = xfer_s && (col_r == COL_LAST) && (line_r == LINE_LAST);

  // Upper half rows are 0..ROWS-1, lower half ROWS..2*ROWS-1 (MSB of row set)
  assign top_addr_s = {bank_r, 1'b0, line_r, col_r};
  assign bot_addr_s = {bank_r, 1'b1, line_r, col_r};
  assign swap_ack   = swap_ack_r;

  // Sticky swap request, applied only on the frame-boundary transfer
  always_ff @(posedge clk) begin
    if (rst) begin
      bank_r     <= 1'b0;
      pend_r     <= 1'b0;
      swap_ack_r <= 1'b0;
    end else begin
      swap_ack_r <= 1'b0;
      if (wrap_s && pend_s) begin
        bank_r     <= ~bank_r;
        pend_r     <= 1'b0;
        swap_ack_r <= 1'b1;
      end else begin
        pend_r <= pend_s;
      end
    end
  end
`else
  assign top_addr_s = {1'b0, line_r, col_r};
  assign bot_addr_s = {1'b1, line_r, col_r};
  // Single-bank build: requests have no effect
  assign swap_ack   = swap_req & 1'b0;
`endif

  // RAM strobe/address decode from the registered state; address holds when idle
  always_comb begin
    rd_s   = 1'b0;
    addr_s = addr_hold_r;
    if (rst) begin
      rd_s   = 1'b0;
      addr_s = {AW{1'b0}};
    end else begin
      case (state_r)
        ST_TOP: begin
          if (enable) begin
            rd_s   = 1'b1;
            addr_s = top_addr_s;
          end else begin
            rd_s   = 1'b0;
            addr_s = addr_hold_r;
          end
        end
        ST_BOT: begin
          rd_s   = 1'b1;
          addr_s = bot_addr_s;
        end
        default: begin
          rd_s   = 1'b0;
          addr_s = addr_hold_r;
        end
      endcase
    end
  end

  assign fb_rd   = rd_s;
  assign fb_addr = addr_s;

  // Fetch FSM: two reads, capture, then hold the pair until accepted
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_TOP;
      col_r       <= {CW{1'b0}};
      line_r      <= {LW{1'b0}};
      top_hold_r  <= 3'b000;
      pair_r      <= hub75_pair_t'(6'b000000);
      pix_valid_r <= 1'b0;
      pix_line_r  <= {LW{1'b0}};
      pix_last_r  <= 1'b0;
      addr_hold_r <= {AW{1'b0}};
    end else begin
      if (rd_s) begin
        addr_hold_r <= addr_s;
      end
      case (state_r)
        ST_TOP: begin
          if (enable) begin
            state_r <= ST_BOT;
          end else begin
            state_r <= ST_TOP;
          end
        end
        ST_BOT: begin
          top_hold_r <= fb_rdata;
          state_r    <= ST_CAP;
        end
        ST_CAP: begin
          pair_r.rgb1 <= top_hold_r;
          pair_r.rgb2 <= fb_rdata;
          pix_line_r  <= line_r;
          pix_last_r  <= (col_r == COL_LAST);
          pix_valid_r <= 1'b1;
          state_r     <= ST_HOLD;
        end
        ST_HOLD: begin
          if (xfer_s) begin
            pix_valid_r <= 1'b0;
            state_r     <= ST_TOP;
            // Power-of-two geometry: line wraps naturally at the frame end
            if (col_r == COL_LAST) begin
              col_r  <= {CW{1'b0}};
              line_r <= line_r + LW'(1);
            end else begin
              col_r <= col_r + CW'(1);
            end
          end else begin
            state_r <= ST_HOLD;
          end
        end
        default: begin
          state_r <= ST_TOP;
        end
      endcase
    end
  end

  assign pix_valid = pix_valid_r;
  assign pix_rgb1  = pair_r.rgb1;
  assign pix_rgb2  = pair_r.rgb2;
  assign pix_line  = pix_line_r;
  assign pix_last  = pix_last_r;

endmodule

// File: tb/tb_hub75_frame_reader.sv
// Scoreboard bench for hub75_frame_reader (default 64x32 geometry).
// Expected pairs are pushed when a phase is set up; a negedge monitor
// pops and compares on every valid/ready transfer.
module tb_hub75_frame_reader;

  localparam int CW      = 6;
  localparam int LW      = 5;
  localparam int BOT_BIT = CW + LW;
`ifdef HUB75_FB_SWAP_EN
  localparam int AW = 13;
`else
  localparam int AW = 12;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic          fb_rd;
  logic [AW-1:0] fb_addr;
  logic [2:0]    fb_rdata;
  logic          pix_valid;
  logic          pix_ready;
  logic [2:0]    pix_rgb1;
  logic [2:0]    pix_rgb2;
  logic [LW-1:0] pix_line;
  logic          pix_last;
  logic          swap_req;
  logic          swap_ack;

  int checks   = 0;
  int errors   = 0;
  int cyc      = 0;
  int xfer_cnt = 0;
  int ack_cnt  = 0;
  int xfer_cyc [2];
  logic [11:0]   exp_q [$];
  logic [LW-1:0] m_line;
  logic [CW-1:0] m_col;

  hub75_frame_reader dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .fb_rd     (fb_rd),
    .fb_addr   (fb_addr),
    .fb_rdata  (fb_rdata),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .pix_rgb1  (pix_rgb1),
    .pix_rgb2  (pix_rgb2),
    .pix_line  (pix_line),
    .pix_last  (pix_last),
    .swap_req  (swap_req),
    .swap_ack  (swap_ack)
  );

  always #5 clk = ~clk;

  // RAM content: XOR of the 3-bit groups of {row, col}; bank bit not used
  function automatic logic [2:0] ram_word(input logic [11:0] a);
    return a[2:0] ^ a[5:3] ^ a[8:6] ^ a[11:9];
  endfunction

  // Framebuffer RAM with one cycle of read latency
  always @(posedge clk) begin
    if (fb_rd) fb_rdata <= ram_word(fb_addr[11:0]);
  end

  // Cycle counter for latency/interval measurements
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Push the pair for the model position, then advance the model scan
  task automatic push_next();
    exp_q.push_back({ram_word({1'b0, m_line, m_col}), ram_word({1'b1, m_line, m_col}),
                     m_line, (m_col == 6'd63)});
    if (m_col == 6'd63) begin
      m_col  = 6'd0;
      m_line = m_line + 5'd1;
    end else begin
      m_col = m_col + 6'd1;
    end
  endtask

  // Monitor: compare every accepted pair against the scoreboard head
  always @(negedge clk) begin
    if (!rst && pix_valid && pix_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pair_unexpected actual=%0h expected=none",
                 {pix_rgb1, pix_rgb2, pix_line, pix_last});
      end else begin
        chk("pair", {pix_rgb1, pix_rgb2, pix_line, pix_last}, exp_q.pop_front());
      end
      if (xfer_cnt < 2) xfer_cyc[xfer_cnt] = cyc;
      xfer_cnt++;
    end
  end

  // Count swap acknowledge pulses
  always @(negedge clk) begin
    if (swap_ack) ack_cnt++;
  end

  task automatic wait_size_below(input int n, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (exp_q.size() < n) break;
      @(negedge clk); #1;
    end
    chk("queue_progress", (exp_q.size() < n), 1);
  endtask

  task automatic wait_drain(input int budget);
    wait_size_below(1, budget);
  endtask

  task automatic wait_bot(input int budget);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (fb_rd && fb_addr[BOT_BIT]) begin
        seen = 1'b1;
        break;
      end
    end
    chk("bot_fetch_seen", seen, 1);
  endtask

  initial begin
    int lat;
    int quiet;
    logic seen;
    rst = 1'b1; enable = 1'b1; pix_ready = 1'b1; swap_req = 1'b0;
    m_line = 5'd0; m_col = 6'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", pix_valid, 0);
    chk("rst_fb_rd", fb_rd, 0);
    chk("rst_fb_addr", fb_addr, 0);
    chk("rst_rgb1", pix_rgb1, 0);
    chk("rst_rgb2", pix_rgb2, 0);
    chk("rst_line", pix_line, 0);
    chk("rst_last", pix_last, 0);
    chk("rst_swap_ack", swap_ack, 0);

    // Full frame plus two pairs of the next one
    for (int i = 0; i < 2050; i++) push_next();
    @(posedge clk); #1 rst = 1'b0;
    lat = 0;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #1;
      if (pix_valid) begin
        lat = i;
        break;
      end
    end
    chk("first_valid_latency", lat, 3);

    // Stall the column-5 pair for 10 cycles
    for (int i = 0; i < 100; i++) begin
      if (xfer_cnt >= 5) break;
      @(negedge clk); #1;
    end
    chk("five_pairs_taken", xfer_cnt, 5);
    chk("pair_interval", xfer_cyc[1] - xfer_cyc[0], 4);
    @(posedge clk); #1 pix_ready = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (pix_valid) begin
        seen = 1'b1;
        break;
      end
    end
    chk("col5_valid", seen, 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall_hold", {pix_valid, fb_rd, pix_rgb1, pix_rgb2, pix_line, pix_last},
          {1'b1, 1'b0, 3'd5, 3'd1, 5'd0, 1'b0});
    end
    @(posedge clk); #1 pix_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (fb_rd) begin
        seen = 1'b1;
        break;
      end
    end
    chk("resume_rd", seen, 1);
    chk("resume_addr", fb_addr, 6);
    wait_drain(10000);

    // Drop enable during the lower-half fetch
    push_next();
    wait_bot(10);
    enable = 1'b0;
    wait_drain(20);
    @(posedge clk);
    quiet = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (fb_rd || pix_valid) quiet++;
    end
    chk("enable_gate", quiet, 0);
    @(posedge clk); #1 enable = 1'b1;
    push_next();
    wait_drain(20);

    // Reset while the FSM is in CAP
    wait_bot(10);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_cap_outputs", {pix_valid, fb_rd, fb_addr, pix_rgb1, pix_rgb2, pix_line, pix_last, swap_ack}, 0);
    m_line = 5'd0; m_col = 6'd0;
    push_next();
    push_next();
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("restart_rd", fb_rd, 1);
    chk("restart_addr", fb_addr, 0);
    wait_drain(20);

`ifdef HUB75_FB_SWAP_EN
    // Two requests during one frame collapse to one swap at the boundary
    while (!(m_line == 5'd0 && m_col == 6'd0)) push_next();
    wait_size_below(1800, 2000);
    @(posedge clk); #1 swap_req = 1'b1;
    @(posedge clk); #1 swap_req = 1'b0;
    wait_size_below(1000, 4000);
    @(posedge clk); #1 swap_req = 1'b1;
    @(posedge clk); #1 swap_req = 1'b0;
    wait_drain(10000);
    chk("bank_before_wrap", fb_addr[AW-1], 0);
    chk("ack_before_wrap", ack_cnt, 0);
    @(posedge clk);
    @(negedge clk);
    chk("swap_ack_pulse", swap_ack, 1);
    chk("bank_after_wrap", {fb_rd, fb_addr[AW-1]}, 2'b11);
    push_next();
    wait_drain(20);
    chk("swap_ack_count", ack_cnt, 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hub75_frame_reader.md
# hub75_frame_reader

Pixel source for the HUB75 shift stage. It walks a 1-bit-per-channel framebuffer held in external synchronous RAM and emits one upper/lower pixel pair per column over a valid/ready handshake. Each pair is tagged with its scan line and an end-of-line flag. The block sits between the framebuffer RAM and the HUB75 shifter/latch FSM, replacing the fixed solid-colour source.

## Interface
Parameters:
- `WIDTH`, 64: columns per line; power of two.
- `ROWS`, 32: scan lines, equal to half the panel height; power of two.
- `AW`, $clog2(2*ROWS*WIDTH) (+1 when `HUB75_FB_SWAP_EN` is defined): framebuffer address width.

Ports:
- `clk` in 1: system clock, 27 MHz.
- `rst` in 1: synchronous, active-high reset.
- `enable` in 1: when low, no new fetch starts; a fetch already in flight completes.
- `fb_rd` out 1: RAM read strobe.
- `fb_addr` out AW: address laid out as {bank (swap only), row[log2(2*ROWS)-1:0], col[log2(WIDTH)-1:0]}.
- `fb_rdata` in 3: {B,G,R}; valid exactly 1 cycle after `fb_rd`.
- `pix_valid` out 1: output pair available.
- `pix_ready` in 1: consumer accepts the pair.
- `pix_rgb1` out 3: upper-half pixel {B,G,R}, row = line.
- `pix_rgb2` out 3: lower-half pixel, row = line+ROWS.
- `pix_line` out log2(ROWS): scan line of the pair.
- `pix_last` out 1: pair is column WIDTH-1.
- `swap_req` in 1: request a bank swap (swap build only).
- `swap_ack` out 1: 1-cycle pulse when the swap takes effect (swap build only).

## Operation
- FSM states: TOP, BOT, CAP, HOLD.
  - TOP, entered when `enable`=1: `fb_rd`=1, address = {bank, line, col}; go to BOT. If `enable`=0, stay in TOP with `fb_rd`=0.
  - BOT: `fb_rd`=1, address = {bank, line+ROWS, col}; register `fb_rdata` into the top holding register; go to CAP.
  - CAP: register `fb_rdata` into `pix_rgb2`, move the top holding register to `pix_rgb1`, set `pix_valid`=1; go to HOLD.
  - HOLD: wait for `pix_valid && pix_ready`. On transfer: `pix_valid`=0, advance col/line, go to TOP.
- Advance rule: col+1. When col=WIDTH-1, col wraps to 0 and line+1. When line=ROWS-1 and col=WIDTH-1, both wrap to 0; this is the frame boundary.
- `pix_line` and `pix_last` are registered together with the data. `pix_last` = (col==WIDTH-1).
- While `pix_valid`=1 and `pix_ready`=0, all `pix_*` outputs stay stable.
- `pix_ready` asserted while `pix_valid`=0 is ignored.
- `fb_addr` keeps its last value when `fb_rd`=0.

## Timing
- Reset values: `pix_valid`=0, `pix_rgb1`=`pix_rgb2`=0, `pix_line`=0, `pix_last`=0, `fb_rd`=0, `fb_addr`=0, col=line=0, bank=0, `swap_ack`=0, state=TOP.
- First `pix_valid` appears 3 cycles after reset deassert, given `enable`=1 (TOP, BOT, CAP, then valid).
- Transfer in cycle N gives the next `pix_valid` at N+4, so peak throughput is one pair per 4 cycles.
- `rst` overrides all other inputs. Reset mid-fetch discards the in-flight data.
- `enable` falling during BOT or CAP: the pair still completes. Only the TOP entry is gated.

## Configuration
- `HUB75_FB_SWAP_EN` defined:
  - A bank register forms the address MSB.
  - `swap_req` sets a sticky pending flag. The flag is applied on the frame-boundary transfer: bank toggles, the flag clears, and `swap_ack` pulses in the cycle after that transfer.
  - `swap_req` arriving in the same cycle as the boundary transfer is applied at that boundary.
  - Further requests while the flag is pending merge into it.
- `HUB75_FB_SWAP_EN` undefined: no bank bit, `swap_req` is ignored, `swap_ack` is tied to 0, and AW has no bank bit.

## Structure
- Shared package `hub75_pkg` holds the RGB pair typedef ({rgb1, rgb2}), the FSM state enum, and the default WIDTH/ROWS constants, shared with the shifter.
- No sub-module is needed. The col/line counter may be split out as `hub75_scan_counter` if the shifter reuses it.

## Test plan
- Reset, `enable`=1, `pix_ready`=1, RAM word = address[2:0]: first pair at cycle 3 with line 0, col 0, rgb1=0, rgb2 = low bits of address 64×... = 0. Pairs then follow every 4 cycles with correct rgb values.
- `pix_ready`=0 for 10 cycles at col 5: outputs stay frozen and `fb_rd` stays 0. On release, col 6 is fetched.
- Full frame: check `pix_last` on every 64th pair, line incrementing 0→31, then wrap to line 0, col 0.
- `enable` dropped in BOT: the current pair is delivered, then no `fb_rd` until `enable` returns.
- Swap build: `swap_req` pulse mid-frame means the bank bit in `fb_addr` flips only after the line-31/col-63 transfer, with `swap_ack` pulsed once. A second `swap_req` during pending still produces a single toggle.
- `rst` asserted in CAP: the next cycle shows all outputs at reset values, and the restart fetches line 0, col 0.
